// File: rtl/mult_booth_iter_if.sv
// Operand/result handshake bundle for the iterative Booth multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface mult_booth_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   is_signed;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output in_valid, a, b, is_signed, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, is_signed, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mult_booth_iter.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle into a double-width
// accumulator, with valid/ready on both sides and flush cancellation.
module mult_booth_iter #(
    parameter int unsigned WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    mult_booth_iter_if.slave   bus
);
    // Two extra bits let unsigned operands go through the signed recoding.
    localparam int unsigned EW = WIDTH + 2;
    localparam int unsigned N  = EW / 2;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [2*EW-1:0]     acc_q, acc_d;
    logic [2*EW-1:0]     mcand_q, mcand_d;
    logic [EW:0]         mplier_q, mplier_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  result_q, result_d;

    logic [EW-1:0]       a_ext, b_ext;
    logic [2*EW-1:0]     term, acc_sum;
    logic                neg;

    assign a_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    assign b_ext = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

    // Booth digit select; negation is ~X with the +1 carried into the same add.
    always_comb begin
        term = '0;
        neg  = 1'b0;
        unique case (mplier_q[2:0])
            3'b001, 3'b010: term = mcand_q;
            3'b011:         term = mcand_q << 1;
            3'b100: begin
                term = mcand_q << 1;
                neg  = 1'b1;
            end
            3'b101, 3'b110: begin
                term = mcand_q;
                neg  = 1'b1;
            end
            default: ;
        endcase
    end

    assign acc_sum = acc_q + (neg ? ~term : term) + {{(2*EW-1){1'b0}}, neg};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && !bus.flush) begin
                    state_d  = StBusy;
                    acc_d    = '0;
                    mcand_d  = {{EW{a_ext[EW-1]}}, a_ext};
                    mplier_d = {b_ext, 1'b0};
                    cnt_d    = CW'(N - 1);
                end
            end
            StBusy: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 2;
                mplier_d = {{2{mplier_q[EW]}}, mplier_q[EW:2]};
                if (cnt_q == '0) begin
                    if (!bus.flush) begin
                        state_d  = StDone;
                        result_d = acc_sum[2*WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (bus.flush) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_mult_booth_iter.sv
// Directed bench for mult_booth_iter at WIDTH=32: products, latency, backpressure,
// flush and asynchronous reset, plus a short randomised run against a 64-bit product.
module tb_mult_booth_iter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mult_booth_iter_if #(.WIDTH(32)) bus ();

    mult_booth_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT idle; returns the same way.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op, input logic ts,
                          input logic [63:0] exp, input string tag, input int stall);
        int lat;
        bus.a         = ta;
        bus.b         = tb_op;
        bus.is_signed = ts;
        bus.in_valid  = 1'b1;
        chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.a         = ~ta;
        bus.b         = ~tb_op;
        bus.is_signed = ~ts;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd17);
        chk({tag, "_result"}, bus.result, exp);
        repeat (stall) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle_after"}, {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    endtask

    initial begin
        logic [31:0]        ra, rb;
        logic               rs;
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, gold;
        bit                 seen;
        int                 waitc;

        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_result", bus.result, 64'd0);
        rst = 1'b0;
        tick();

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, "s_m1_m1", 0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "u_max_max", 0);
        run_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "s_min_min", 0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, "s_min_1", 0);
        run_op(32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, "u_min_2", 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF, "u_max_1", 0);
        run_op(32'h00000007, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFF9, "s_7_m1", 0);
        run_op(32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFF1, "s_m3_5", 0);
        run_op(32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, "u_2p16_sq", 0);
        run_op(32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000, "s_zero", 0);

        // Backpressure: result held while out_ready stays low.
        bus.a = 32'd2; bus.b = 32'd3; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        waitc = 0;
        while (!bus.out_valid && waitc < 40) begin
            tick();
            waitc++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_result", bus.result, 64'd6);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

        // Flush on the fifth BUSY cycle.
        bus.a = 32'd7; bus.b = 32'd9; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_no_result", {63'd0, seen}, 64'd0);
        run_op(32'd3, 32'd5, 1'b0, 64'd15, "after_flush", 0);

        // Flush wins over in_valid in IDLE.
        bus.a = 32'd4; bus.b = 32'd4; bus.in_valid = 1'b1; bus.flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("flush_blocks_accept", {63'd0, bus.in_ready}, 64'd1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_blocks_result", {63'd0, seen}, 64'd0);

        // Asynchronous reset mid-BUSY.
        bus.a = 32'd3; bus.b = 32'd5; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        tick();
        rst = 1'b0;
        tick();
        run_op(32'd6, 32'd7, 1'b1, 64'd42, "after_rst", 0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom();
            rb = $urandom();
            rs = 1'($urandom_range(0, 1));
            sa = {{32{ra[31]}}, ra};
            sb = {{32{rb[31]}}, rb};
            ua = {32'd0, ra};
            ub = {32'd0, rb};
            gold = rs ? 64'(sa * sb) : ua * ub;
            run_op(ra, rb, rs, gold, "rand", $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
